// File: rtl/dram_rd_arbiter.sv
// Round-robin arbiter that shares one DRAM read port among NUM_REQ fetch
// engines. A granted burst issues one address per cycle, and the returned
// words are routed back to the granted requester with one cycle of latency.
//
// Handshake: a requester raises req_valid[i] and holds req_valid, req_addr
// and req_len stable until it sees req_ready[i]. req_ready is a single-cycle
// registered pulse, so the burst is accepted in the cycle where both are high.
// After that, dropping req_valid does not affect the burst. Response beats
// carry no back-pressure: rsp_valid[i] is a one-cycle strobe per word.
module dram_rd_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int ADDR_WIDTH = 18,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 10
) (
  input  logic                            clk,
  input  logic                            srstn,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ*LEN_WIDTH-1:0]    req_len,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic                            dram_en_rd,
  output logic [ADDR_WIDTH-1:0]           dram_addr_rd,
  input  logic                            dram_valid,
  input  logic [DATA_WIDTH-1:0]           dram_data_rd,
  output logic [NUM_REQ-1:0]              rsp_valid,
  output logic [DATA_WIDTH-1:0]           rsp_data,
  output logic                            rsp_last,
  output logic                            busy,
  output logic                            err_stray,
  output logic [1:0]                      state_dbg
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  // One extra bit so a burst of 2^LEN_WIDTH beats can be counted.
  localparam int CNT_W = LEN_WIDTH + 1;
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                state;
  logic [PTR_W-1:0]      rr_ptr;
  logic [PTR_W-1:0]      gnt;
  logic [ADDR_WIDTH-1:0] base;
  logic [LEN_WIDTH-1:0]  len;
  logic [CNT_W-1:0]      issue_cnt;
  logic [CNT_W-1:0]      rx_cnt;

  logic [CNT_W-1:0]      len_ext;
  logic [CNT_W-1:0]      issue_next;
  logic                  beat_ok;
  logic                  beat_last;

  logic [2*NUM_REQ-1:0]  req_dbl;
  logic [NUM_REQ-1:0]    req_rot;
  logic                  pick_found;
  logic [PTR_W-1:0]      pick_off;
  logic [PTR_W:0]        pick_sum;
  logic [PTR_W-1:0]      pick_idx;
  logic [PTR_W:0]        pick_inc;
  logic [PTR_W-1:0]      ptr_after;
  logic [ADDR_WIDTH-1:0] pick_addr;
  logic [LEN_WIDTH-1:0]  pick_len;

  assign len_ext    = {1'b0, len};
  assign issue_next = issue_cnt + CNT_W'(1);

  // A return is a real beat only while a burst is active and still owes data.
  assign beat_ok   = dram_valid && (state != IDLE) && (rx_cnt <= len_ext);
  assign beat_last = beat_ok && (rx_cnt == len_ext);

  // Rotate the request vector so that bit 0 is the requester at rr_ptr.
  assign req_dbl = {req_valid, req_valid};
  assign req_rot = NUM_REQ'(req_dbl >> rr_ptr);

  // Find the first pending requester at or after rr_ptr.
  always_comb begin
    pick_found = 1'b0;
    pick_off   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        pick_found = 1'b1;
        pick_off   = PTR_W'(k);
      end
    end
  end

  assign pick_sum  = {1'b0, rr_ptr} + {1'b0, pick_off};
  assign pick_idx  = (pick_sum >= (PTR_W+1)'(NUM_REQ)) ?
                     PTR_W'(pick_sum - (PTR_W+1)'(NUM_REQ)) : PTR_W'(pick_sum);
  assign pick_inc  = {1'b0, pick_idx} + (PTR_W+1)'(1);
  assign ptr_after = (pick_inc == (PTR_W+1)'(NUM_REQ)) ? '0 : PTR_W'(pick_inc);
  assign pick_addr = req_addr[int'(pick_idx)*ADDR_WIDTH +: ADDR_WIDTH];
  assign pick_len  = req_len[int'(pick_idx)*LEN_WIDTH +: LEN_WIDTH];

  assign busy      = (state != IDLE);
  assign state_dbg = state;

  // Grant, address issue and response routing, all from registers.
  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      gnt          <= '0;
      base         <= '0;
      len          <= '0;
      issue_cnt    <= '0;
      rx_cnt       <= '0;
      req_ready    <= '0;
      dram_en_rd   <= 1'b0;
      dram_addr_rd <= '0;
      rsp_valid    <= '0;
      rsp_data     <= '0;
      rsp_last     <= 1'b0;
      err_stray    <= 1'b0;
    end else begin
      req_ready <= '0;
      rsp_valid <= '0;
      rsp_last  <= 1'b0;

      if (beat_ok) begin
        rsp_valid <= ONE_HOT0 << gnt;
        rsp_data  <= dram_data_rd;
        rsp_last  <= beat_last;
        rx_cnt    <= rx_cnt + CNT_W'(1);
      end
      if (dram_valid && !beat_ok) begin
        err_stray <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (pick_found) begin
            req_ready    <= ONE_HOT0 << pick_idx;
            gnt          <= pick_idx;
            base         <= pick_addr;
            len          <= pick_len;
            rr_ptr       <= ptr_after;
            issue_cnt    <= '0;
            rx_cnt       <= '0;
            dram_en_rd   <= 1'b1;
            dram_addr_rd <= pick_addr;
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          if (issue_cnt == len_ext) begin
            dram_en_rd   <= 1'b0;
            dram_addr_rd <= '0;
            state        <= DRAIN;
          end else begin
            issue_cnt    <= issue_next;
            dram_addr_rd <= base + ADDR_WIDTH'(issue_next);
          end
        end
        DRAIN: begin
          if (beat_last || (rx_cnt == len_ext + CNT_W'(1))) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dram_rd_arbiter.sv
// Self-checking bench for dram_rd_arbiter: a bench-side round-robin model,
// a DRAM model with random return latency, and a response scoreboard.
module tb_dram_rd_arbiter;

  localparam int NR = 3;
  localparam int AW = 18;
  localparam int DW = 32;
  localparam int LW = 10;
  localparam int EW = 36;  // {req[2:0], last, data[31:0]}

  typedef struct {
    int          r;
    logic [AW-1:0] addr;
    int          len;
  } burst_t;

  typedef struct {
    int          due;
    logic [DW-1:0] data;
    int          req;
    bit          last;
    int          epoch;
  } ret_t;

  logic              clk = 1'b0;
  logic              srstn;
  logic [NR-1:0]     req_valid;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*LW-1:0]  req_len;
  logic [NR-1:0]     req_ready;
  logic              dram_en_rd;
  logic [AW-1:0]     dram_addr_rd;
  logic              dram_valid = 1'b0;
  logic [DW-1:0]     dram_data_rd = '0;
  logic [NR-1:0]     rsp_valid;
  logic [DW-1:0]     rsp_data;
  logic              rsp_last;
  logic              busy;
  logic              err_stray;
  logic [1:0]        state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  logic [EW-1:0] exp_q[$];
  burst_t        bq[$];
  burst_t        job_q[$];
  ret_t          ret_q[$];

  int            cyc = 0;
  int            iss_idx = 0;
  int            iss_k = 0;
  int            last_due = 0;
  int            lat_min = 1;
  int            lat_max = 8;
  int            epoch = 0;
  int            m_rr = 0;
  bit            inject = 1'b0;
  bit            gap_check = 1'b0;
  int            last_cyc = 0;
  int            gap_hits = 0;
  logic [NR-1:0] pend_snap = '0;
  logic [NR-1:0] acc_mask = '0;
  int            n_issue = 0;
  int            n_rsp = 0;
  int            n_last = 0;

  dram_rd_arbiter #(
    .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)
  ) dut (
    .clk(clk), .srstn(srstn),
    .req_valid(req_valid), .req_addr(req_addr), .req_len(req_len),
    .req_ready(req_ready),
    .dram_en_rd(dram_en_rd), .dram_addr_rd(dram_addr_rd),
    .dram_valid(dram_valid), .dram_data_rd(dram_data_rd),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_last(rsp_last),
    .busy(busy), .err_stray(err_stray), .state_dbg(state_dbg)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Monitor, round-robin model, DRAM model and scoreboard, all at the falling edge.
  always @(negedge clk) begin
    int er;
    int idx;
    logic [AW-1:0] ea;
    logic [EW-1:0] e;
    ret_t rt;
    burst_t b;
    cyc++;
    if (srstn) begin
      if (req_ready != '0) begin
        er = -1;
        for (int k = NR - 1; k >= 0; k--) begin
          idx = (m_rr + k) % NR;
          if (pend_snap[idx]) er = idx;
        end
        if (er < 0) begin
          check_eq("grant_unexpected", 64'(req_ready), 64'd0);
        end else begin
          check_eq("grant_onehot", 64'(req_ready), 64'(1) << er);
          if (gap_check) begin
            check_eq("b2b_gap", 64'(cyc - last_cyc), 64'd1);
            gap_hits++;
          end
          gap_check = 1'b0;
          b.r    = er;
          b.addr = req_addr[er*AW +: AW];
          b.len  = int'(req_len[er*LW +: LW]);
          bq.push_back(b);
          m_rr = (er + 1) % NR;
          acc_mask[er] = 1'b1;
        end
      end
      if (dram_en_rd) begin
        n_issue++;
        check_eq("busy_issue", 64'(busy), 64'd1);
        if (iss_idx >= bq.size()) begin
          check_eq("issue_extra", 64'(dram_en_rd), 64'd0);
        end else begin
          ea = bq[iss_idx].addr + AW'(iss_k);
          check_eq("issue_addr", 64'(dram_addr_rd), 64'(ea));
          rt.due = cyc + int'($urandom_range(lat_max, lat_min));
          if (rt.due <= last_due) rt.due = last_due + 1;
          last_due = rt.due;
          rt.data  = $urandom;
          rt.req   = bq[iss_idx].r;
          rt.last  = (iss_k == bq[iss_idx].len);
          rt.epoch = epoch;
          ret_q.push_back(rt);
          if (iss_k == bq[iss_idx].len) begin
            iss_idx++;
            iss_k = 0;
          end else begin
            iss_k++;
          end
        end
      end
      if (rsp_valid != '0) begin
        n_rsp++;
        if (exp_q.size() == 0) begin
          check_eq("rsp_extra", 64'(rsp_valid), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check_eq("rsp_owner", 64'(rsp_valid), 64'(1) << e[35:33]);
          check_eq("rsp_data", 64'(rsp_data), 64'(e[31:0]));
          check_eq("rsp_last", 64'(rsp_last), 64'(e[32]));
        end
      end
      if (rsp_last) begin
        n_last++;
        check_eq("busy_after_last", 64'(busy), 64'd0);
        last_cyc  = cyc;
        gap_check = (req_valid != '0);
      end
    end
    dram_valid = 1'b0;
    if (ret_q.size() > 0 && ret_q[0].due <= cyc) begin
      rt = ret_q.pop_front();
      dram_valid   = 1'b1;
      dram_data_rd = rt.data;
      if (rt.epoch == epoch) exp_q.push_back({3'(rt.req), rt.last, rt.data});
    end else if (inject) begin
      dram_valid   = 1'b1;
      dram_data_rd = $urandom;
      inject = 1'b0;
    end
    pend_snap = req_valid;
  end

  // Driver: drop accepted requests, raise the next queued job per requester.
  task automatic feed();
    for (int r = 0; r < NR; r++) begin
      if (acc_mask[r]) begin
        acc_mask[r]  = 1'b0;
        req_valid[r] = 1'b0;
      end
      if (!req_valid[r]) begin
        for (int j = 0; j < job_q.size(); j++) begin
          if (job_q[j].r == r) begin
            req_addr[r*AW +: AW] = job_q[j].addr;
            req_len[r*LW +: LW]  = LW'(job_q[j].len);
            req_valid[r] = 1'b1;
            job_q.delete(j);
            break;
          end
        end
      end
    end
  endtask

  task automatic add_job(input int r, input logic [AW-1:0] a, input int l);
    burst_t b;
    b.r = r; b.addr = a; b.len = l;
    job_q.push_back(b);
  endtask

  // Run queued jobs until everything has issued and returned, within budget.
  task automatic serve(input int budget);
    bit done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      @(posedge clk); #1;
      feed();
      done = (job_q.size() == 0) && (req_valid == '0) && (acc_mask == '0) &&
             (iss_idx == bq.size()) && (iss_k == 0) && (ret_q.size() == 0) &&
             (exp_q.size() == 0) && !busy;
    end
    check_eq("serve_done", 64'(done), 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int i0, r0, l0, g0;
    bit reached;
    srstn     = 1'b0;
    req_valid = '0;
    req_addr  = '0;
    req_len   = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_req_ready", 64'(req_ready), 64'd0);
    check_eq("rst_en_rd", 64'(dram_en_rd), 64'd0);
    check_eq("rst_addr_rd", 64'(dram_addr_rd), 64'd0);
    check_eq("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check_eq("rst_rsp_last", 64'(rsp_last), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_err", 64'(err_stray), 64'd0);
    check_eq("rst_state", 64'(state_dbg), 64'd0);
    srstn = 1'b1;

    // Single burst
    i0 = n_issue; r0 = n_rsp; l0 = n_last;
    add_job(0, 18'h00100, 3);
    serve(200);
    check_eq("single_issues", 64'(n_issue - i0), 64'd4);
    check_eq("single_rsps", 64'(n_rsp - r0), 64'd4);
    check_eq("single_lasts", 64'(n_last - l0), 64'd1);

    // Address wrap
    add_job(2, 18'h3FFFE, 3);
    serve(200);

    // Back-to-back: requester 1 waits while requester 0 drains
    g0 = gap_hits;
    add_job(0, 18'h01000, 7);
    add_job(1, 18'h02000, 5);
    serve(300);
    check_eq("b2b_seen", 64'(gap_hits - g0), 64'd1);

    // Round-robin with all three requesters kept busy
    for (int b = 0; b < 3; b++)
      for (int r = 0; r < NR; r++)
        add_job(r, AW'(18'h10000 + r * 'h100 + b * 'h10), int'($urandom_range(5, 0)));
    serve(1000);

    // Maximum length burst
    i0 = n_issue; r0 = n_rsp; l0 = n_last;
    add_job(1, 18'h20000, 1023);
    serve(3000);
    check_eq("max_issues", 64'(n_issue - i0), 64'd1024);
    check_eq("max_rsps", 64'(n_rsp - r0), 64'd1024);
    check_eq("max_lasts", 64'(n_last - l0), 64'd1);
    check_eq("err_clean", 64'(err_stray), 64'd0);

    // Stray return in IDLE
    @(posedge clk); #1;
    inject = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("stray_set", 64'(err_stray), 64'd1);
    repeat (10) @(posedge clk);
    #1;
    check_eq("stray_sticky", 64'(err_stray), 64'd1);

    // Reset in the middle of a burst, with late returns afterwards
    lat_min = 8; lat_max = 8;
    i0 = n_issue;
    reached = 1'b0;
    add_job(0, 18'h00400, 15);
    for (int c = 0; c < 50 && !reached; c++) begin
      @(posedge clk); #1;
      feed();
      reached = (n_issue - i0 >= 4);
    end
    check_eq("midburst_reached", 64'(reached), 64'd1);
    srstn = 1'b0;
    #1;
    check_eq("abort_en_rd", 64'(dram_en_rd), 64'd0);
    check_eq("abort_addr", 64'(dram_addr_rd), 64'd0);
    check_eq("abort_req_ready", 64'(req_ready), 64'd0);
    check_eq("abort_rsp_valid", 64'(rsp_valid), 64'd0);
    check_eq("abort_busy", 64'(busy), 64'd0);
    check_eq("abort_err", 64'(err_stray), 64'd0);
    epoch++;
    exp_q.delete();
    bq.delete();
    job_q.delete();
    iss_idx = 0; iss_k = 0;
    req_valid = '0; acc_mask = '0;
    gap_check = 1'b0; m_rr = 0;
    repeat (2) @(posedge clk);
    #1;
    srstn = 1'b1;
    for (int c = 0; c < 40 && ret_q.size() > 0; c++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
    check_eq("late_err", 64'(err_stray), 64'd1);
    check_eq("late_busy", 64'(busy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
